imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory. It receives a framed byte stream over a valid/ready handshake and writes it into the byte-addressable instruction store, using the same big-endian byte order the fetch path reads.
- It holds the processor (cpu_hold) while a program image is loading, then validates the image with a checksum and reports done or error.
- It sits between the host/UART byte source and the instruction memory write port.

Parameters:
- MEM_BYTES, 100, instruction store size in bytes; MAX_WORDS = MEM_BYTES/4 = 25.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum clk cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  byte source has data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- mem_we  out  1  single-cycle byte write strobe.
- mem_addr  out  32  byte address, same width as PC.
- mem_wdata  out  8  byte to write.
- cpu_hold  out  1  keep processor stalled/in reset.
- load_done  out  1  sticky: last frame loaded and checksum good.
- load_err  out  1  sticky: last frame failed.
- words_loaded  out  8  words written in the current or last frame.

Behaviour:
- Reset (reset==0 at clk edge), every output: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0. State=IDLE, byte counter=0, checksum=0, timeout counter=0.
- Reset mid-frame aborts the frame immediately. Bytes already written stay in memory. No further writes occur.
- in_ready is 1 in every state after reset; the loader never back-pressures.
- Frame format: SYNC_BYTE, LEN (word count N), 4N data bytes, CSUM. The frame is good when (sum of data bytes + CSUM) mod 256 == 0.
- IDLE / DONE / ERR:
  - Accepted byte == SYNC_BYTE -> LEN. Same edge: load_done=0, load_err=0, cpu_hold=1, checksum=0, words_loaded=0.
  - Any other byte is discarded; state unchanged.
- LEN:
  - Accepted N with 1<=N<=MAX_WORDS -> DATA. Latch N; byte index=0.
  - N==0 or N>MAX_WORDS -> ERR.
- DATA:
  - Each accepted byte at index i registers mem_addr=i and mem_wdata=byte, and pulses mem_we for exactly one cycle on the following cycle (1-cycle write latency).
  - Byte i goes to address i, so the first byte received is the MSB of word 0 (big-endian, matches fetch).
  - Checksum accumulates mod 256.
  - words_loaded increments when i[1:0]==3 is accepted.
  - After byte 4N-1 -> CSUM.
  - Bytes are written regardless of value; SYNC_BYTE carries no special meaning inside DATA.
- CSUM:
  - Accepted byte with total == 0 -> DONE: load_done=1, cpu_hold=0.
  - Otherwise -> ERR: load_err=1, cpu_hold stays 1 so a corrupt image never runs.
- ERR via LEN also sets load_err=1 and keeps cpu_hold=1.
- Timeout:
  - In LEN/DATA/CSUM, a counter increments on every cycle without an accepted byte and clears on every accepted byte.
  - Reaching TIMEOUT -> ERR with load_err=1.
  - Counter clears on entering IDLE/DONE/ERR.
- mem_we is never asserted outside DATA-sourced writes. At most one write per accepted byte. mem_addr < MEM_BYTES always.
- Only a new SYNC_BYTE (or reset) leaves ERR or DONE. A SYNC arriving in DONE re-asserts cpu_hold.
- load_done and load_err are never both 1.

Test Plan:
- Reset, then A5, 01, 22, 52, 00, 04, 88 back-to-back -> four mem_we pulses at addr 0..3 with data 22/52/00/04, each one cycle after its byte; load_done=1; cpu_hold 1 during frame, 0 after CSUM; words_loaded=1.
- Same frame with CSUM=89 -> memory written, load_err=1, load_done=0, cpu_hold remains 1.
- A5, 00 and A5, 1A (26 > 25) -> ERR after LEN byte, no mem_we pulses, load_err=1.
- Garbage bytes 11, FF in IDLE, then a valid 2-word frame with in_valid toggling randomly -> garbage ignored; addr 0..7 written in order; load_done=1.
- A5, 01, 22, then idle for TIMEOUT cycles -> load_err=1 exactly at TIMEOUT; only addr 0 written. A following good frame -> load_done=1, load_err=0.
- reset driven 0 during DATA after 2 bytes -> next edge all outputs at reset values, no more writes. A new frame after release loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: accepts a framed byte stream (SYNC, LEN, 4*LEN data bytes, CSUM)
// and writes the data bytes big-endian into the instruction store. The CPU is
// held while a frame is in flight and after any failed frame.
module imem_loader #(
    parameter int         MEM_BYTES = 100,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  words_loaded
);

    localparam int MAX_WORDS = MEM_BYTES / 4;
    localparam int IDX_W     = $clog2(MEM_BYTES);
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  byte_idx, byte_idx_nx;
    logic [IDX_W-1:0]  last_idx, last_idx_nx;
    logic [7:0]        checksum, checksum_nx;
    logic [7:0]        csum_total;
    logic [TO_W-1:0]   tcnt, tcnt_nx;
    logic              mem_we_nx;
    logic [31:0]       mem_addr_nx;
    logic [7:0]        mem_wdata_nx;
    logic              cpu_hold_nx;
    logic              load_done_nx;
    logic              load_err_nx;
    logic [7:0]        words_nx;
    logic              accept;
    logic              in_frame;

    assign accept   = in_valid & in_ready;
    assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);

    // Next-state and next-output logic: frame parsing, checksum, inter-byte timeout.
    always_comb begin
        state_nx     = state;
        byte_idx_nx  = byte_idx;
        last_idx_nx  = last_idx;
        checksum_nx  = checksum;
        tcnt_nx      = tcnt;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        cpu_hold_nx  = cpu_hold;
        load_done_nx = load_done;
        load_err_nx  = load_err;
        words_nx     = words_loaded;
        csum_total   = checksum + in_data;

        if (in_frame) begin
            if (accept) begin
                tcnt_nx = '0;
            end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                tcnt_nx     = '0;
                state_nx    = S_ERR;
                load_err_nx = 1'b1;
            end else begin
                tcnt_nx = tcnt + 1'b1;
            end
        end else begin
            tcnt_nx = '0;
        end

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_nx     = S_LEN;
                    load_done_nx = 1'b0;
                    load_err_nx  = 1'b0;
                    cpu_hold_nx  = 1'b1;
                    checksum_nx  = 8'd0;
                    words_nx     = 8'd0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if ((in_data == 8'd0) || (in_data > 8'(MAX_WORDS))) begin
                        state_nx    = S_ERR;
                        load_err_nx = 1'b1;
                    end else begin
                        state_nx    = S_DATA;
                        byte_idx_nx = '0;
                        last_idx_nx = IDX_W'({in_data, 2'b00} - 10'd1);
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = 32'(byte_idx);
                    mem_wdata_nx = in_data;
                    checksum_nx  = checksum + in_data;
                    if (byte_idx[1:0] == 2'b11) begin
                        words_nx = words_loaded + 8'd1;
                    end
                    if (byte_idx == last_idx) begin
                        state_nx = S_CSUM;
                    end else begin
                        byte_idx_nx = byte_idx + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (csum_total == 8'd0) begin
                        state_nx     = S_DONE;
                        load_done_nx = 1'b1;
                        cpu_hold_nx  = 1'b0;
                    end else begin
                        state_nx    = S_ERR;
                        load_err_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register; a low reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and output registers; writes leave one cycle after their byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready     <= 1'b0;
            byte_idx     <= '0;
            last_idx     <= '0;
            checksum     <= 8'd0;
            tcnt         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 8'd0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= 8'd0;
        end else begin
            in_ready     <= 1'b1;
            byte_idx     <= byte_idx_nx;
            last_idx     <= last_idx_nx;
            checksum     <= checksum_nx;
            tcnt         <= tcnt_nx;
            mem_we       <= mem_we_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            cpu_hold     <= cpu_hold_nx;
            load_done    <= load_done_nx;
            load_err     <= load_err_nx;
            words_loaded <= words_nx;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed byte streams into imem_loader and compares every
// output each cycle against a frame-position model of the loader.
module tb_imem_loader;

    localparam int         MEM_BYTES = 100;
    localparam int         MAX_WORDS = MEM_BYTES / 4;
    localparam int         TIMEOUT   = 1000;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [7:0]  words_loaded;

    int pass_count  = 0;
    int check_count = 0;

    imem_loader #(
        .MEM_BYTES(MEM_BYTES),
        .SYNC_BYTE(SYNC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Model state: frame position instead of a state machine.
    // m_pos < 0 : waiting for SYNC; 0 : expecting LEN; 1..m_nbytes : data byte m_pos-1;
    // m_nbytes+1 : expecting CSUM.
    logic        m_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = 32'd0;
    logic [7:0]  m_wdata = 8'd0;
    logic        m_hold  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;
    logic [7:0]  m_words = 8'd0;
    int          m_pos    = -1;
    int          m_nbytes = 0;
    int          m_sum    = 0;
    int          m_idle   = 0;
    logic [7:0]  m_mem   [MEM_BYTES];
    logic [7:0]  dut_mem [MEM_BYTES];
    int          wr_count = 0;

    // Reference model, advanced on each rising edge from the sampled inputs.
    always @(posedge clk) begin : model
        bit acc;
        if (!reset) begin
            m_valid = 1'b1;
            m_ready = 1'b0;
            m_we    = 1'b0;
            m_addr  = 32'd0;
            m_wdata = 8'd0;
            m_hold  = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_words = 8'd0;
            m_pos   = -1;
            m_idle  = 0;
        end else begin
            acc     = in_valid && m_ready;
            m_ready = 1'b1;
            m_we    = 1'b0;
            if (m_pos < 0) begin
                if (acc && in_data == SYNC) begin
                    m_pos   = 0;
                    m_done  = 1'b0;
                    m_err   = 1'b0;
                    m_hold  = 1'b1;
                    m_sum   = 0;
                    m_words = 8'd0;
                    m_idle  = 0;
                end
            end else if (!acc) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_err = 1'b1;
                    m_pos = -1;
                end
            end else begin
                m_idle = 0;
                if (m_pos == 0) begin
                    if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
                        m_err = 1'b1;
                        m_pos = -1;
                    end else begin
                        m_nbytes = 4 * int'(in_data);
                        m_pos    = 1;
                    end
                end else if (m_pos <= m_nbytes) begin
                    m_we             = 1'b1;
                    m_addr           = 32'(m_pos - 1);
                    m_wdata          = in_data;
                    m_mem[m_pos - 1] = in_data;
                    m_sum            = (m_sum + int'(in_data)) % 256;
                    m_words          = 8'(m_pos / 4);
                    m_pos++;
                end else begin
                    if ((m_sum + int'(in_data)) % 256 == 0) begin
                        m_done = 1'b1;
                        m_hold = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_pos = -1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("in_ready",     32'(in_ready),     32'(m_ready));
            checkOutput("mem_we",       32'(mem_we),       32'(m_we));
            checkOutput("mem_addr",     mem_addr,          m_addr);
            checkOutput("mem_wdata",    32'(mem_wdata),    32'(m_wdata));
            checkOutput("cpu_hold",     32'(cpu_hold),     32'(m_hold));
            checkOutput("load_done",    32'(load_done),    32'(m_done));
            checkOutput("load_err",     32'(load_err),     32'(m_err));
            checkOutput("words_loaded", 32'(words_loaded), 32'(m_words));
        end
    end

    // Capture the DUT's write traffic into a shadow memory.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_count++;
            if (mem_addr < 32'(MEM_BYTES)) begin
                dut_mem[int'(mem_addr)] = mem_wdata;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte after a random idle gap of up to max_gap cycles.
    task automatic applyStimulus(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic doReset();
        reset    = 1'b0;
        in_valid = 1'b0;
        waitCycles(2);
        reset = 1'b1;
        waitCycles(1);
    endtask

    // kind 0: good checksum, 1: corrupt checksum, 2: illegal length.
    task automatic sendRandomFrame(input int kind, input int max_gap);
        logic [7:0] q[$];
        int n;
        int sum;
        logic [7:0] b;
        q.push_back(SYNC);
        if (kind == 2) begin
            if ($urandom_range(0, 1) == 0) q.push_back(8'd0);
            else q.push_back(8'($urandom_range(MAX_WORDS + 1, 255)));
        end else begin
            n   = $urandom_range(1, MAX_WORDS);
            sum = 0;
            q.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) begin
                b   = 8'($urandom);
                sum = sum + int'(b);
                q.push_back(b);
            end
            b = 8'((256 - (sum % 256)) % 256);
            if (kind == 1) b = b + 8'($urandom_range(1, 255));
            q.push_back(b);
        end
        foreach (q[i]) applyStimulus(q[i], max_gap);
    endtask

    logic [7:0] frame1 [7];
    logic [7:0] frame4 [11];
    logic [7:0] garbage;
    int         wr0;
    int         found;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            m_mem[i]   = 8'd0;
            dut_mem[i] = 8'd0;
        end
        frame1 = '{8'hA5, 8'h01, 8'h22, 8'h52, 8'h00, 8'h04, 8'h88};
        frame4 = '{8'hA5, 8'h02, 8'h01, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h0A};

        doReset();

        // Good one-word frame, back to back.
        foreach (frame1[i]) applyStimulus(frame1[i], 0);
        waitCycles(2);
        checkOutput("t1_done",  32'(load_done),    32'd1);
        checkOutput("t1_hold",  32'(cpu_hold),     32'd0);
        checkOutput("t1_words", 32'(words_loaded), 32'd1);
        checkOutput("t1_mem0",  32'(dut_mem[0]),   32'h22);
        checkOutput("t1_mem1",  32'(dut_mem[1]),   32'h52);
        checkOutput("t1_mem2",  32'(dut_mem[2]),   32'h00);
        checkOutput("t1_mem3",  32'(dut_mem[3]),   32'h04);

        // Same frame with a corrupt checksum.
        frame1[6] = 8'h89;
        foreach (frame1[i]) applyStimulus(frame1[i], 0);
        waitCycles(2);
        checkOutput("t2_err",  32'(load_err),  32'd1);
        checkOutput("t2_done", 32'(load_done), 32'd0);
        checkOutput("t2_hold", 32'(cpu_hold),  32'd1);

        // Illegal lengths: zero and MAX_WORDS+1.
        wr0 = wr_count;
        applyStimulus(SYNC, 0);
        applyStimulus(8'h00, 0);
        checkOutput("t3_err_len0", 32'(load_err), 32'd1);
        applyStimulus(SYNC, 0);
        applyStimulus(8'h1A, 0);
        waitCycles(2);
        checkOutput("t3_err_len26", 32'(load_err), 32'd1);
        checkOutput("t3_no_writes", 32'(wr_count - wr0), 32'd0);

        // Garbage then a two-word frame with random gaps; data holds a SYNC byte.
        applyStimulus(8'h11, 3);
        applyStimulus(8'hFF, 3);
        wr0 = wr_count;
        foreach (frame4[i]) applyStimulus(frame4[i], 3);
        waitCycles(2);
        checkOutput("t4_done",   32'(load_done),      32'd1);
        checkOutput("t4_writes", 32'(wr_count - wr0), 32'd8);
        checkOutput("t4_mem1",   32'(dut_mem[1]),     32'hA5);
        checkOutput("t4_mem7",   32'(dut_mem[7]),     32'h60);
        checkOutput("t4_words",  32'(words_loaded),   32'd2);

        // Timeout after one data byte.
        wr0 = wr_count;
        applyStimulus(SYNC, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h22, 0);
        found = -1;
        for (int n = 1; n <= TIMEOUT + 5; n++) begin
            waitCycles(1);
            if (load_err === 1'b1 && found < 0) found = n;
        end
        checkOutput("t5_timeout_cycle", 32'(found),          32'(TIMEOUT));
        checkOutput("t5_writes",        32'(wr_count - wr0), 32'd1);
        sendRandomFrame(0, 1);
        waitCycles(2);
        checkOutput("t5_recover_done", 32'(load_done), 32'd1);
        checkOutput("t5_recover_err",  32'(load_err),  32'd0);

        // Reset during DATA after two bytes.
        applyStimulus(SYNC, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'($urandom), 0);
        applyStimulus(8'($urandom), 0);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        waitCycles(1);
        wr0 = wr_count;
        checkOutput("t6_rst_we",    32'(mem_we),       32'd0);
        checkOutput("t6_rst_addr",  mem_addr,          32'd0);
        checkOutput("t6_rst_hold",  32'(cpu_hold),     32'd0);
        checkOutput("t6_rst_ready", 32'(in_ready),     32'd0);
        checkOutput("t6_rst_words", 32'(words_loaded), 32'd0);
        waitCycles(1);
        in_valid = 1'b0;
        reset    = 1'b1;
        waitCycles(3);
        checkOutput("t6_no_writes", 32'(wr_count - wr0), 32'd0);
        sendRandomFrame(0, 2);
        waitCycles(2);
        checkOutput("t6_after_done", 32'(load_done), 32'd1);

        // Randomized frames of mixed kinds with interleaved garbage.
        for (int f = 0; f < 10; f++) begin
            repeat ($urandom_range(0, 2)) begin
                garbage = 8'($urandom_range(0, 254));
                if (garbage == SYNC) garbage = 8'h00;
                applyStimulus(garbage, 2);
            end
            case ($urandom_range(0, 9))
                0, 1:    sendRandomFrame(1, 2);
                2:       sendRandomFrame(2, 2);
                default: sendRandomFrame(0, 2);
            endcase
        end
        waitCycles(3);

        for (int i = 0; i < MEM_BYTES; i++) begin
            checkOutput("mem_final", 32'(dut_mem[i]), 32'(m_mem[i]));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
